// File: rtl/conv_layer_output_interface.sv
`default_nettype none
// ============================================================================
//  Module   : conv_layer_output_interface
//  Purpose  : Accepts one feature vector (ARRAY_SIZE words) from the conv
//             kernel array and writes it word-by-word into external feature
//             RAM through an auto-incrementing, wrapping address pointer.
//  Options  : OUTPUT_RELU_EN - rectify each word (sign set -> +0.0) at latch
//  Revision : 1.0 - initial release
// ============================================================================
module conv_layer_output_interface #(
    parameter int ARRAY_SIZE = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_LIMIT = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature,
    input  logic                             feature_valid,
    input  logic                             addr_clear,
    output logic                             ready,
    output logic [ADDR_WIDTH-1:0]            ext_ram_addr,
    output logic [DATA_WIDTH-1:0]            ext_ram_data,
    output logic                             ext_ram_we,
    output logic                             done,
    output logic                             wrap
);

    localparam int VEC_W = ARRAY_SIZE * DATA_WIDTH;
    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    localparam logic [ADDR_WIDTH-1:0] C_BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] C_LIMIT = ADDR_WIDTH'(ADDR_LIMIT);
    localparam logic [IDX_W-1:0]      C_LAST  = IDX_W'(ARRAY_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [VEC_W-1:0]        shreg_q, shreg_d;
    logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0]   last_data_q, last_data_d;

    logic [VEC_W-1:0]        latch_vec;
    logic [DATA_WIDTH-1:0]   cur_word;

    // Per-word conditioning of the incoming vector before it is latched
    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_word
        localparam int HI = VEC_W - 1 - g * DATA_WIDTH;
`ifdef OUTPUT_RELU_EN
        // Any word with the sign bit set (including -0.0) becomes +0.0
        assign latch_vec[HI -: DATA_WIDTH] =
            feature[HI] ? '0 : feature[HI -: DATA_WIDTH];
`else
        assign latch_vec[HI -: DATA_WIDTH] = feature[HI -: DATA_WIDTH];
`endif
    end

    // Word 0 sits at the top of the shift register and is written first
    assign cur_word = shreg_q[VEC_W-1 -: DATA_WIDTH];

    // Next-state, datapath and output decode
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        last_addr_d  = last_addr_q;
        last_data_d  = last_data_q;
        ready        = 1'b0;
        ext_ram_we   = 1'b0;
        ext_ram_addr = last_addr_q;
        ext_ram_data = last_data_q;
        done         = 1'b0;
        wrap         = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                // Clear takes effect before a same-cycle accept, so the
                // accepted vector starts at BASE_ADDR
                if (addr_clear) begin
                    wr_ptr_d = C_BASE;
                end
                if (feature_valid) begin
                    shreg_d = latch_vec;
                    idx_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ext_ram_we   = 1'b1;
                ext_ram_addr = wr_ptr_q;
                ext_ram_data = cur_word;
                last_addr_d  = wr_ptr_q;
                last_data_d  = cur_word;
                shreg_d      = shreg_q << DATA_WIDTH;
                if (wr_ptr_q == C_LIMIT) begin
                    wrap     = 1'b1;
                    wr_ptr_d = C_BASE;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                end
                if (idx_q == C_LAST) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any vector in flight
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= C_BASE;
            idx_q       <= '0;
            shreg_q     <= '0;
            last_addr_q <= C_BASE;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_output_interface.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_layer_output_interface
//  Purpose  : Directed self-checking bench for conv_layer_output_interface
//  Options  : OUTPUT_RELU_EN - expected data follows the rectified words
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_output_interface;

    localparam int C_N     = 6;
    localparam int C_DW    = 32;
    localparam int C_AW    = 8;
    localparam int C_VEC_W = C_N * C_DW;

    logic               clk;
    logic               rst_n;
    logic [C_VEC_W-1:0] feature;
    logic               feature_valid;
    logic               addr_clear;
    logic               ready;
    logic [C_AW-1:0]    ext_ram_addr;
    logic [C_DW-1:0]    ext_ram_data;
    logic               ext_ram_we;
    logic               done;
    logic               wrap;

    int n_cmp;
    int n_bad;
    int exp_ptr;

    conv_layer_output_interface #(
        .ARRAY_SIZE (C_N),
        .DATA_WIDTH (C_DW),
        .ADDR_WIDTH (C_AW),
        .BASE_ADDR  (0),
        .ADDR_LIMIT (255)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .feature       (feature),
        .feature_valid (feature_valid),
        .addr_clear    (addr_clear),
        .ready         (ready),
        .ext_ram_addr  (ext_ram_addr),
        .ext_ram_data  (ext_ram_data),
        .ext_ram_we    (ext_ram_we),
        .done          (done),
        .wrap          (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef OUTPUT_RELU_EN
        return w[31] ? 32'h0000_0000 : w;
`else
        return w;
`endif
    endfunction

    // Offer vector v, then walk the whole write/done/ready sequence checking
    // every cycle against the bench's own pointer model
    task automatic send_vec(input logic [C_VEC_W-1:0] v,
                            input logic [C_VEC_W-1:0] v_after,
                            input bit keep_valid,
                            input bit clr_acc,
                            input bit clr_during);
        logic [C_VEC_W-1:0] vv;
        vv            = v;
        feature       = v;
        feature_valid = 1'b1;
        addr_clear    = clr_acc;
        check("accept_ready", 32'(ready), 32'd1);
        tick();
        if (clr_acc) exp_ptr = 0;
        feature       = v_after;
        feature_valid = keep_valid;
        addr_clear    = clr_during;
        for (int i = 0; i < C_N; i++) begin
            check("wr_we",    32'(ext_ram_we), 32'd1);
            check("wr_addr",  32'(ext_ram_addr), 32'(exp_ptr));
            check("wr_data",  ext_ram_data, exp_word(vv[C_VEC_W-1-i*C_DW -: C_DW]));
            check("wr_wrap",  32'(wrap), (exp_ptr == 255) ? 32'd1 : 32'd0);
            check("wr_ready", 32'(ready), 32'd0);
            check("wr_done",  32'(done), 32'd0);
            exp_ptr = (exp_ptr == 255) ? 0 : exp_ptr + 1;
            tick();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_we",    32'(ext_ram_we), 32'd0);
        check("done_ready", 32'(ready), 32'd0);
        check("done_wrap",  32'(wrap), 32'd0);
        tick();
        addr_clear = 1'b0;
        check("back_ready", 32'(ready), 32'd1);
        check("back_done",  32'(done), 32'd0);
        check("back_we",    32'(ext_ram_we), 32'd0);
    endtask

    logic [C_VEC_W-1:0] vec_a, vec_b, vec_c, vec_relu, vec_k;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_ptr = 0;
        rst_n = 1'b1;
        feature = '0;
        feature_valid = 1'b0;
        addr_clear = 1'b0;

        vec_a    = {32'h3F800000, 32'h40000000, 32'h40400000,
                    32'h40800000, 32'h40A00000, 32'h40C00000};
        vec_b    = {32'h11111111, 32'h22222222, 32'h33333333,
                    32'h44444444, 32'h55555555, 32'h66666666};
        vec_c    = {32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D,
                    32'h3A3B3C3D, 32'h4A4B4C4D, 32'h5A5B5C5D};
        vec_relu = {32'hBF800000, 32'h3F800000, 32'h80000000,
                    32'h00000000, 32'hC2C80000, 32'h42C80000};

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we",    32'(ext_ram_we), 32'd0);
        check("rst_addr",  32'(ext_ram_addr), 32'd0);
        check("rst_data",  ext_ram_data, 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_wrap",  32'(wrap), 32'd0);
        rst_n = 1'b0;
        tick();
        check("idle_ready", 32'(ready), 32'd1);

        // Single vector to addresses 0..5
        send_vec(vec_a, vec_b, 1'b0, 1'b0, 1'b0);

        // addr_clear held through WRITE is ignored: 6..11
        send_vec(vec_b, vec_c, 1'b0, 1'b0, 1'b1);
        check("hold_addr", 32'(ext_ram_addr), 32'd11);
        check("hold_data", ext_ram_data, 32'h66666666);

        // Back-to-back with valid held high; bus changes mid-write: 12..17, 18..23
        send_vec(vec_a, vec_b, 1'b1, 1'b0, 1'b0);
        send_vec(vec_b, vec_c, 1'b0, 1'b0, 1'b0);

        // Clear together with valid in IDLE: vector lands at 0..5
        send_vec(vec_c, vec_a, 1'b0, 1'b1, 1'b0);

        // Stand-alone clear, then 42 vectors filling 0..251
        addr_clear = 1'b1;
        tick();
        addr_clear = 1'b0;
        exp_ptr = 0;
        for (int k = 0; k < 42; k++) begin
            vec_k = '0;
            for (int i = 0; i < C_N; i++)
                vec_k[C_VEC_W-1-i*C_DW -: C_DW] = 32'(k * 256 + i);
            send_vec(vec_k, vec_k, 1'b0, 1'b0, 1'b0);
        end
        check("fill_ptr", 32'(exp_ptr), 32'd252);
        // Wrapping vector: 252,253,254,255,0,1
        send_vec(vec_a, vec_b, 1'b0, 1'b0, 1'b0);

        // Reset during the third write
        feature = vec_b;
        feature_valid = 1'b1;
        tick();
        feature_valid = 1'b0;
        tick();
        tick();
        check("mid_we",   32'(ext_ram_we), 32'd1);
        check("mid_addr", 32'(ext_ram_addr), 32'(exp_ptr + 2));
        rst_n = 1'b1;
        tick();
        check("abort_we",    32'(ext_ram_we), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_addr",  32'(ext_ram_addr), 32'd0);
        check("abort_done",  32'(done), 32'd0);
        rst_n = 1'b0;
        tick();
        check("post_done",  32'(done), 32'd0);
        check("post_ready", 32'(ready), 32'd1);
        exp_ptr = 0;
        send_vec(vec_c, vec_a, 1'b0, 1'b0, 1'b0);

        // Sign-handling vector (rectified only when the option is built)
        send_vec(vec_relu, vec_a, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_layer_output_interface.md
Name: conv_layer_output_interface

Overview:
Write-side counterpart of the conv layer input interface. It takes one feature vector (ARRAY_SIZE words) from the conv kernel array's output bus and serializes it into external feature RAM, one word per cycle, through an auto-incrementing address pointer. The conv layer controller drives it with a valid/ready handshake and a done pulse. It sits between the conv kernel array and the activation or pooling stage memory.

Parameters:
ARRAY_SIZE, 6, number of DATA_WIDTH words in one feature vector
DATA_WIDTH, 32, word width (IEEE-754 single)
ADDR_WIDTH, 8, external RAM address width
BASE_ADDR, 0, pointer value after reset or addr_clear
ADDR_LIMIT, 255, last valid address; the pointer wraps from ADDR_LIMIT to BASE_ADDR

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-high (1 = reset)
feature  in  ARRAY_SIZE*DATA_WIDTH  feature vector; word 0 = bits [ARRAY_SIZE*DATA_WIDTH-1 -: DATA_WIDTH]
feature_valid  in  1  feature holds a vector to store
addr_clear  in  1  reset the write pointer to BASE_ADDR
ready  out  1  block can accept a vector
ext_ram_addr  out  ADDR_WIDTH  write address
ext_ram_data  out  DATA_WIDTH  write data
ext_ram_we  out  1  write enable, one word per high cycle
done  out  1  1-cycle pulse after the last word of a vector is written
wrap  out  1  1-cycle pulse, coincident with the write to ADDR_LIMIT

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - state=IDLE, wr_ptr=BASE_ADDR, word index=0, shift register=0.
  - ready=1, ext_ram_we=0, ext_ram_addr=BASE_ADDR, ext_ram_data=0, done=0, wrap=0.
  - Reset during WRITE aborts the vector immediately. Words already written stay in RAM; no done pulse is issued.
- FSM states: IDLE, WRITE, DONE.
  - IDLE: ready=1. On feature_valid=1, latch feature into the shift register and go to WRITE. Only this transfer is an accepted handshake.
  - WRITE: ready=0, ext_ram_we=1, ext_ram_data=current word (word 0 first), ext_ram_addr=wr_ptr. Each cycle: shift by one word, wr_ptr+1, index+1. After the ARRAY_SIZE-th write, go to DONE.
  - DONE: done=1, ready=0, ext_ram_we=0. Next cycle go to IDLE.
- Latency, with the accept at edge 0:
  - Writes occur in cycles 1..ARRAY_SIZE.
  - done is high in cycle ARRAY_SIZE+1.
  - ready returns in cycle ARRAY_SIZE+2.
  - Throughput is one vector per ARRAY_SIZE+2 cycles.
- feature_valid while ready=0 is ignored. The feature bus is sampled only at acceptance; later changes have no effect.
- Pointer: increments by 1 per write, ADDR_WIDTH unsigned. When a write is to ADDR_LIMIT, wrap=1 in that cycle and the next pointer is BASE_ADDR. Wrap can occur mid-vector; the vector continues at BASE_ADDR.
- addr_clear:
  - Honoured only in IDLE; ignored in WRITE and DONE.
  - With addr_clear and feature_valid in the same IDLE cycle, the clear applies first and the vector's first word goes to BASE_ADDR.
- ext_ram_data and ext_ram_addr are don't-care when ext_ram_we=0. The implementation holds their last values.
- No arithmetic on data except the optional feature below.

Optional Feature:
OUTPUT_RELU_EN
- Defined: each word is rectified when latched. If bit DATA_WIDTH-1 (sign) is 1, the stored word becomes 32'h0000_0000 (+0.0); otherwise it passes unchanged. -0.0 (32'h8000_0000) also becomes 32'h0000_0000. Timing is unchanged.
- Undefined: words are written bit-exact, and no rectification logic is built.

Test Plan:
1. Reset, then feature words {3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000} with one-cycle feature_valid -> writes to addresses 0..5 in order, data matching, ext_ram_we high exactly 6 cycles, done in cycle 7, ready back in cycle 8.
2. Two back-to-back vectors with feature_valid held high -> second accepted only when ready=1, written to addresses 6..11; vector change during WRITE does not corrupt the first vector's data.
3. Accept 42 vectors (addresses 0..251), then one more -> writes 252,253,254,255,0,1; wrap pulses with the write to 255; done still follows the 6th word.
4. addr_clear during WRITE ignored (vector completes at addresses 6..11); then addr_clear together with feature_valid in IDLE -> vector written to addresses 0..5.
5. rst_n asserted during the 3rd write -> next cycle ext_ram_we=0, ready=1, pointer=0, no done; the next vector lands at addresses 0..5.
6. With OUTPUT_RELU_EN, words {BF800000, 3F800000, 80000000, 00000000, C2C80000, 42C80000} -> RAM receives {0, 3F800000, 0, 0, 0, 42C80000}; without it, the same words are written bit-exact.
